// File: rtl/reg_file_sb.sv
// reg_file_sb: 32x32 integer register file with a load-use scoreboard.
//
// This block sits between ID and WB. WB writes through
// Ctl_RegWrite_in/Rd_in/WriteDatatoReg_in. ID reads rs1/rs2 through
// combinational ports. A busy bit per register tracks loads that have
// been issued but whose writeback has not yet happened. ID gets a stall
// request while a source register it really reads is still busy.
// x0 is hardwired to zero.
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   defined   : the read ports forward same-cycle WB data (write-before-read),
//               and a WB retiring a busy register suppresses its stall.
//   undefined : the read ports return stored values only, so a stall
//               releases one cycle after the WB write.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   Ctl_RegWrite_in, Rd_in,
//   WriteDatatoReg_in               writeback port from WB
//   Rs1_in, Rs2_in                  ID source register indices
//   Rs1_used_in, Rs2_used_in        ID instruction really reads that source
//   issue_valid_in, issue_load_in,
//   issue_rd_in                     instruction leaving ID: valid, is-load, rd
//   flush_in                        pipeline flush; clears every busy bit
//   Rs1Data_out, Rs2Data_out        read data
//   Hazard_stall_out                load-use stall request to PC/IF/ID
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Ctl_RegWrite_in,
    input  logic [4:0]      Rd_in,
    input  logic [XLEN-1:0] WriteDatatoReg_in,
    input  logic [4:0]      Rs1_in,
    input  logic [4:0]      Rs2_in,
    input  logic            Rs1_used_in,
    input  logic            Rs2_used_in,
    input  logic            issue_valid_in,
    input  logic            issue_load_in,
    input  logic [4:0]      issue_rd_in,
    input  logic            flush_in,
    output logic [XLEN-1:0] Rs1Data_out,
    output logic [XLEN-1:0] Rs2Data_out,
    output logic            Hazard_stall_out
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic wb_write;
    logic load_issue;
    logic covers1;
    logic covers2;
    logic hz1;
    logic hz2;

    assign wb_write   = Ctl_RegWrite_in && (Rd_in != 5'd0);
    assign load_issue = issue_valid_in && issue_load_in && (issue_rd_in != 5'd0);

    // Priority is encoded by statement order: clear, then set (a newer
    // load to the same rd wins), then flush overrides everything.
    always_comb begin
        busy_next = busy;
        if (wb_write)
            busy_next[Rd_in] = 1'b0;
        if (load_issue)
            busy_next[issue_rd_in] = 1'b1;
        if (flush_in)
            busy_next = '0;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wb_write)
                regs[Rd_in] <= WriteDatatoReg_in;
            busy <= busy_next;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign covers1 = wb_write && (Rd_in == Rs1_in);
    assign covers2 = wb_write && (Rd_in == Rs2_in);
`else
    assign covers1 = 1'b0;
    assign covers2 = 1'b0;
`endif

    always_comb begin
        Rs1Data_out = regs[Rs1_in];
        Rs2Data_out = regs[Rs2_in];
        if (covers1)
            Rs1Data_out = WriteDatatoReg_in;
        if (covers2)
            Rs2Data_out = WriteDatatoReg_in;
        // Gating on rst_n keeps a bypassed WB value from leaking out
        // while the block is held in reset.
        if (Rs1_in == 5'd0 || !rst_n)
            Rs1Data_out = '0;
        if (Rs2_in == 5'd0 || !rst_n)
            Rs2Data_out = '0;
    end

    assign hz1 = Rs1_used_in && (Rs1_in != 5'd0) && busy[Rs1_in] && !covers1;
    assign hz2 = Rs2_used_in && (Rs2_in != 5'd0) && busy[Rs2_in] && !covers2;
    assign Hazard_stall_out = hz1 || hz2;

endmodule
